// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Drives an external 16-bit ripple-carry adder. It runs one 16-bit chunk per
//   cycle, LSB chunk first, and builds a WORDS x 16-bit add or subtract from
//   those chunks. A chunk's carry-out is registered and becomes the carry-in
//   of the next chunk.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake; in_ready is high only in IDLE
//   op_a, op_b             W-bit operands, sampled only at the accept edge
//   op_cin                 carry-in for add (ignored when op_sub=1)
//   op_sub                 1 = A - B, computed as A + ~B + 1
//   out_valid / out_ready  result handshake; out_valid is high only in DONE
//   result                 W-bit sum/difference, held stable in DONE
//   result_cout            final carry-out (for subtract, 1 = no borrow)
//   overflow               two's-complement signed overflow of the W-bit op
//   add_a, add_b, add_cin  chunk operands driven to the external adder
//   add_sum, add_cout      external adder outputs

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                op_cin,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                result_cout,
  output logic                overflow,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_sum,
  input  logic                add_cout
);

  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;          // holds ~op_b for subtract
  logic [W-1:0]  result_reg;
  logic          carry_reg;
  logic [KW-1:0] k_reg;
  logic          result_cout_reg;
  logic          overflow_reg;

  // Operands split into chunks so the adder inputs come from a plain chunk mux.
  logic [15:0] a_chunk [WORDS];
  logic [15:0] b_chunk [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[16*gi +: 16];
      assign b_chunk[gi] = b_reg[16*gi +: 16];
    end
  endgenerate

  logic running;
  assign running = (state_reg == RUN);

  // The adder inputs are forced to zero outside RUN. This keeps stale
  // operands off the shared adder.
  assign add_a   = running ? a_chunk[k_reg] : 16'd0;
  assign add_b   = running ? b_chunk[k_reg] : 16'd0;
  assign add_cin = running ? carry_reg      : 1'b0;

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign result      = result_reg;
  assign result_cout = result_cout_reg;
  assign overflow    = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      a_reg           <= '0;
      b_reg           <= '0;
      result_reg      <= '0;
      carry_reg       <= 1'b0;
      k_reg           <= '0;
      result_cout_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_sub ? ~op_b : op_b;
            carry_reg <= op_sub ? 1'b1 : op_cin;
            k_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result_reg[{k_reg, 4'b0000} +: 16] <= add_sum;
          carry_reg <= add_cout;
          k_reg     <= k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            result_cout_reg <= add_cout;
            // MSB operand bits ^ MSB sum bit recovers the carry into bit W-1.
            // XOR with the carry out of bit W-1 gives signed overflow.
            overflow_reg <= a_reg[W-1] ^ b_reg[W-1] ^ add_sum[15] ^ add_cout;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         result_cout;
  logic         overflow;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_cin;
  logic [15:0]  add_sum;
  logic         add_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External 16-bit adder.
  logic [16:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  assign add_sum    = adder_full[15:0];
  assign add_cout   = adder_full[16];

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int           cyc = 0;
  bit           started = 0;
  bit           busy = 0;
  int           acc = 0;       // edge index at which the op was accepted
  logic [W-1:0] m_a, m_bv;
  logic         m_cin;
  logic [W-1:0] h_res = '0;
  logic         h_cout = 1'b0;
  logic         h_ovf = 1'b0;

  // Returns the carry into chunk j of a + bv + c. It is taken from a plain
  // wide addition of the lower bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] bv,
                                      input logic c, input int j);
    logic [W:0]   s;
    logic [W-1:0] mask;
    if (j == 0) return c;
    mask = (64'd1 << (16 * j)) - 64'd1;
    s = {1'b0, a & mask} + {1'b0, bv & mask} + 65'(c);
    return s[16*j];
  endfunction

  always @(posedge clk) begin : model
    logic [W:0] full;
    cyc++;
    if (rst) begin
      started = 1;
      busy    = 0;
      h_res   = '0;
      h_cout  = 1'b0;
      h_ovf   = 1'b0;
    end else if (started) begin
      if (!busy) begin
        if (in_valid) begin
          busy  = 1;
          acc   = cyc;
          m_a   = op_a;
          m_bv  = op_sub ? ~op_b : op_b;
          m_cin = op_sub ? 1'b1 : op_cin;
          full  = {1'b0, m_a} + {1'b0, m_bv} + 65'(m_cin);
          h_res  = full[W-1:0];
          h_cout = full[W];
          h_ovf  = (m_a[W-1] == m_bv[W-1]) && (h_res[W-1] != m_a[W-1]);
        end
      end else if ((cyc - 1) >= acc + WORDS && out_ready) begin
        busy = 0;
      end
    end
  end

  // The compare process checks every cycle after the first reset edge.
  always @(negedge clk) begin : compare
    bit run_now, done_now;
    int j;
    if (started) begin
      run_now  = busy && (cyc < acc + WORDS);
      done_now = busy && (cyc >= acc + WORDS);
      check("in_ready",  64'(in_ready),  64'(!busy));
      check("out_valid", 64'(out_valid), 64'(done_now));
      if (run_now) begin
        j = cyc - acc;
        check("add_a",   64'(add_a),   64'(m_a[16*j +: 16]));
        check("add_b",   64'(add_b),   64'(m_bv[16*j +: 16]));
        check("add_cin", 64'(add_cin), 64'(carry_into(m_a, m_bv, m_cin, j)));
      end else begin
        check("add_idle", {add_a, add_b, 31'd0, add_cin}, 64'd0);
        check("result",      result,            h_res);
        check("result_cout", 64'(result_cout),  64'(h_cout));
        check("overflow",    64'(overflow),     64'(h_ovf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input int hold,
                       input bit lit, input logic [W-1:0] er,
                       input logic ec, input logic eo, output logic cin2);
    int n = 0;
    int lat;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // These new values must not affect the operation in flight.
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    op_sub = 1'($urandom); op_cin = 1'($urandom);
    lat  = 1;
    cin2 = 1'b0;
    while (!out_valid && lat < 30) begin
      if (lat == 2) cin2 = add_cin;
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(WORDS + 1));
    if (lit) begin
      check("lit_result",   result,           er);
      check("lit_cout",     64'(result_cout), 64'(ec));
      check("lit_overflow", 64'(overflow),    64'(eo));
    end
    $display("op a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d ovf=%0d hold=%0d",
             a, b, cin, sub, result, result_cout, overflow, hold);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;   // must be ignored in DONE
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin : stim
    logic c2;
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result",    result,         64'd0);

    // Carry from chunk 0 into chunk 1.
    do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 1,
          64'h0000_0000_0001_0000, 1'b0, 1'b0, c2);
    check("chunk1_cin", 64'(c2), 64'd1);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1, 64'd0, 1'b1, 1'b0, c2);
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, 1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, c2);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0, 1,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, c2);
    // Backpressure, then a follow-up request.
    do_op(64'd100, 64'd58, 1'b0, 1'b1, 3, 1, 64'd42, 1'b1, 1'b0, c2);
    do_op(64'd20, 64'd22, 1'b0, 1'b0, 0, 1, 64'd42, 1'b0, 1'b0, c2);

    // Reset while k=2 in RUN.
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h1111_1111_1111_1111;
    op_sub = 1'b0; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;   // k=0
    @(posedge clk); #1;                    // k=1
    @(posedge clk); #1;                    // k=2
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    result,         64'd0);
    check("rst_add",       {add_a, add_b, 31'd0, add_cin}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    do_op(64'd3, 64'd4, 1'b0, 1'b0, 0, 1, 64'd7, 1'b0, 1'b0, c2);

    // Random operations. Some use boundary operands.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 1) ra = '1;
      if (i % 8 == 2) rb = {1'b1, 63'd0};
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            0, '0, 1'b0, 1'b0, c2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequential front/back end for the team's 16-bit ripple-carry adder. It accepts a WORDS×16-bit add or subtract request over a valid/ready handshake. It feeds the 16-bit adder one chunk per cycle, LSB chunk first, registering each chunk's carry into the next, and assembles the wide result. The result is presented on a valid/ready output. The adder is external: this block drives its operand and carry-in inputs and consumes its sum and carry-out outputs.

## Interface
- WORDS, default 4: number of 16-bit chunks. Operand width W = 16*WORDS. Legal values are 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry-in; ignored when op_sub=1.
- op_sub  input  1  1 selects A − B, computed as A + ~B + 1.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference.
- result_cout  output  1  final carry-out. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow of the W-bit operation.
- add_a  output  16  adder operand A chunk.
- add_b  output  16  adder operand B chunk, inverted when subtracting.
- add_cin  output  1  adder carry-in.
- add_sum  input  16  adder sum.
- add_cout  input  1  adder carry-out.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, register op_a and op_b. If op_sub=1, register ~op_b instead of op_b.
  - Initialise the carry register to op_sub ? 1 : op_cin.
  - Clear the chunk index k to 0 and go to RUN.
- RUN:
  - Combinationally drive add_a = A[16k+15:16k], add_b = B'[16k+15:16k], add_cin = carry register.
  - At each edge, write add_sum into result[16k+15:16k], load add_cout into the carry register, and increment k.
  - On the edge where k = WORDS−1:
    - load result_cout ← add_cout;
    - load overflow ← A[W−1] ^ B'[W−1] ^ add_sum[15] ^ add_cout, i.e. the carry into the MSB XOR the carry out of the MSB;
    - go to DONE.
- DONE:
  - out_valid=1. result, result_cout and overflow are held stable.
  - When out_ready=1, go to IDLE.
  - A new request cannot be accepted in DONE. in_ready stays 0.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- No chunk of result written in an earlier operation may be visible as stale data. All WORDS chunks are rewritten every operation.
- Arithmetic is modulo 2^W. The only carry information reported is result_cout and overflow.

## Timing
- Reset is synchronous and takes priority over all other events:
  - state=IDLE, k=0, carry register=0;
  - result=0, result_cout=0, overflow=0, out_valid=0;
  - in_ready=1 from the first cycle after rst deasserts.
- Accept edge T (in_valid & in_ready): RUN occupies cycles T+1 .. T+WORDS.
- out_valid rises at cycle T+WORDS+1, so latency is WORDS+1 cycles.
- Output handshake at edge H (out_valid & out_ready): in_ready=1 in cycle H+1. The earliest next accept is edge H+1.
- Peak throughput is one operation per WORDS+2 cycles.
- in_valid while in_ready=0 is ignored. The requester holds its data until in_ready.
- Reset mid-RUN or in DONE aborts the operation. The in-flight result is discarded and out_valid does not assert for it.
- Operand inputs are sampled only at the accept edge. Changing them during RUN has no effect.

## Test plan
- WORDS=4, op_a=0x0000_0000_0000_FFFF, op_b=1, op_cin=0, op_sub=0, accept at edge T:
  - add_cin=1 into chunk 1 during cycle T+2;
  - out_valid at T+5 with result=0x0000_0000_0001_0000, result_cout=0, overflow=0.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=1, add → result=0, result_cout=1, overflow=0.
- op_sub=1, op_a=0x8000_0000_0000_0000, op_b=1 → result=0x7FFF_FFFF_FFFF_FFFF, result_cout=1, overflow=1.
- op_cin=1, op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=0 → result=0x8000_0000_0000_0000, result_cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid. Then:
  - result is stable, out_valid=1 and in_ready=0 throughout; a pulsed in_valid is ignored;
  - out_ready=1 → in_ready=1 next cycle, and the following request completes correctly.
- Assert rst for one cycle while k=2 in RUN:
  - out_valid stays 0, result=0 and add_* outputs are 0 next cycle;
  - in_ready=1 the cycle after rst drops; a fresh 3+4 request returns result=7.
